// File: rtl/control_unit.sv
// Multicycle RV64I control FSM with run/halt control and an illegal-opcode trap.
// Optional performance counters are built only when CONTROL_UNIT_PERF_CNT_EN is defined.
module control_unit #(
  parameter int RESET_STATE_IDLE = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        run,
  input  logic [6:0]  opcode,
  output logic        WE_RF,
  output logic        WE_MEM,
  output logic [1:0]  RF_din_sel,
  output logic        ULA_din2_sel,
  output logic        load_pc,
  output logic        load_ir,
  output logic        pc_next_sel,
  output logic        pc_adder_sel,
  output logic        halted,
  output logic        trap,
  output logic        instr_done,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEMRD,
    S_TRAP
  } state_t;

  state_t r_state;
  logic   w_legal;

  always_comb begin
    case (opcode)
      OPC_OP, OPC_OP32, OPC_OPIMM, OPC_OPIMM32, OPC_LOAD, OPC_STORE,
      OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: w_legal = 1'b1;
      default:                                           w_legal = 1'b0;
    endcase
  end

  // run only matters in IDLE and on retiring cycles, so a halt never aborts an instruction.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= (RESET_STATE_IDLE != 0) ? S_IDLE : S_FETCH;
    end else begin
      case (r_state)
        S_IDLE:   if (run) r_state <= S_FETCH;
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: r_state <= w_legal ? S_EXEC : S_TRAP;
        S_EXEC: begin
          if (opcode == OPC_LOAD) r_state <= S_MEMRD;
          else                    r_state <= run ? S_FETCH : S_IDLE;
        end
        S_MEMRD:  r_state <= run ? S_FETCH : S_IDLE;
        S_TRAP:   r_state <= S_TRAP;
        default:  r_state <= S_TRAP;
      endcase
    end
  end

  always_comb begin
    WE_RF        = 1'b0;
    WE_MEM       = 1'b0;
    RF_din_sel   = 2'b00;
    ULA_din2_sel = 1'b0;
    load_pc      = 1'b0;
    load_ir      = 1'b0;
    pc_next_sel  = 1'b0;
    pc_adder_sel = 1'b0;
    halted       = (r_state == S_IDLE);
    trap         = (r_state == S_TRAP);
    case (r_state)
      S_FETCH: load_ir = 1'b1;
      S_EXEC: begin
        case (opcode)
          OPC_OP, OPC_OP32: begin
            WE_RF      = 1'b1;
            RF_din_sel = 2'b01;
            load_pc    = 1'b1;
          end
          OPC_OPIMM, OPC_OPIMM32, OPC_LUI: begin
            WE_RF        = 1'b1;
            RF_din_sel   = 2'b01;
            ULA_din2_sel = 1'b1;
            load_pc      = 1'b1;
          end
          OPC_AUIPC: begin
            WE_RF      = 1'b1;
            RF_din_sel = 2'b11;
            load_pc    = 1'b1;
          end
          OPC_JAL, OPC_JALR: begin
            WE_RF        = 1'b1;
            RF_din_sel   = 2'b10;
            pc_next_sel  = 1'b1;
            pc_adder_sel = (opcode == OPC_JALR);
            load_pc      = 1'b1;
          end
          OPC_BRANCH: begin
            pc_next_sel = 1'b1;
            load_pc     = 1'b1;
          end
          OPC_STORE: begin
            ULA_din2_sel = 1'b1;
            WE_MEM       = 1'b1;
            load_pc      = 1'b1;
          end
          OPC_LOAD: ULA_din2_sel = 1'b1;
          default: ;
        endcase
      end
      S_MEMRD: begin
        ULA_din2_sel = 1'b1;
        WE_RF        = 1'b1;
        load_pc      = 1'b1;
      end
      default: ;
    endcase
  end

  assign instr_done = load_pc;

`ifdef CONTROL_UNIT_PERF_CNT_EN
  logic [31:0] r_cycleCnt;
  logic [31:0] r_instretCnt;

  // IDLE and TRAP are not active cycles; both counters wrap naturally.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cycleCnt   <= 32'd0;
      r_instretCnt <= 32'd0;
    end else begin
      if (r_state != S_IDLE && r_state != S_TRAP) r_cycleCnt <= r_cycleCnt + 32'd1;
      if (instr_done) r_instretCnt <= r_instretCnt + 32'd1;
    end
  end

  assign cycle_cnt   = r_cycleCnt;
  assign instret_cnt = r_instretCnt;
`else
  assign cycle_cnt   = 32'd0;
  assign instret_cnt = 32'd0;
`endif

endmodule
